pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter for the NPC datapath. It supports logical left, logical right and arithmetic right shifts, with rotates as a compile-time option. Each of the log2(WIDTH) shift levels is registered, so it sustains one operation per cycle. Valid/ready handshakes on both sides let it sit between the decode/issue stage and writeback, or serve as a standalone test target.

## Interface

- `WIDTH`, 32: data width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width and pipeline depth (derived; not overridden).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `flush`  in  1  synchronous kill of all in-flight operations.
- `in_valid`  in  1  input operation valid.
- `in_ready`  out  1  shifter can accept an input this cycle.
- `din`  in  WIDTH  operand.
- `shamt`  in  SHW  shift amount, 0..WIDTH-1.
- `op`  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; others reserved.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `dout`  out  WIDTH  shifted result.

## Operation

- Pipeline has SHW stages; stage k, for k = 0..SHW-1 with LSB first, shifts or rotates by 2^k when `shamt[k]` = 1, else passes the value through.
- Each stage register holds a valid bit, partial data, the remaining `shamt` bits and `op`.
- Global advance: `adv = !out_valid || out_ready`. `in_ready = adv`, which is combinational.
- When `adv` = 1:
  - every stage loads from its predecessor;
  - stage 0 loads `{in_valid, din, shamt, op}`;
  - bubbles (valid = 0) propagate as ordinary entries and are not collapsed.
- When `adv` = 0, all stage registers hold their values. `dout`/`out_valid` stay stable until taken.
- Per-op fill behaviour:
  - SLL: zero fill at LSBs.
  - SRL: zero fill at MSBs.
  - SRA: fill with the original `din[WIDTH-1]`; the sign bit is carried unchanged through the stages.
  - ROL/ROR: bits wrap around.
- Reserved `op`: the result equals `din` unchanged, regardless of `shamt`.
- `shamt` = 0 on any op: result equals `din`.
- Input accepted when `in_valid && in_ready`; output consumed when `out_valid && out_ready`.

## Timing

- Reset: all stage valid bits = 0, all data registers = 0.
- Outputs after reset: `out_valid` = 0, `dout` = 0, `in_ready` = 1.
- Latency: a result appears with `out_valid` = 1 exactly SHW cycles after the accept edge when not stalled. Each stall cycle adds one cycle.
- Throughput: one result per cycle while `out_ready` = 1.
- Back-pressure: `out_valid` = 1 with `out_ready` = 0 drops `in_ready` in the same cycle, so no input is lost or duplicated.
- `flush` = 1:
  - all valid bits are cleared at the next edge;
  - an input presented in the same cycle is discarded, even though `in_ready` is high;
  - `dout` data may remain, but `out_valid` = 0.
- `flush` and `rst` together: `rst` dominates; the end state is the same.
- `rst` mid-operation: all in-flight results are discarded with no partial output.
- Result field is always exactly WIDTH bits; no overflow flag.

## Configuration

- Macro: `PIPELINED_BARREL_SHIFTER_ROTATE_EN`.
- Defined: ROL (011) and ROR (100) perform rotates as specified.
- Undefined:
  - rotate wrap logic is not synthesised;
  - 011 and 100 become reserved and pass `din` through unchanged;
  - all other behaviour is identical.

## Test plan

- Test plan uses `WIDTH`=8 (latency 3) and `din`=0xD5.
- SRL, `shamt`=1 → `dout`=0x6A after 3 cycles; SRA, `shamt`=2 → 0xF5; SLL, `shamt`=3 → 0xA8.
- Rotates with macro defined: ROL 3 → 0xAE; ROR 1 → 0xEA. Without macro, same stimulus → 0xD5.
- Back-to-back stream of 8 ops with `out_ready`=1 → 8 consecutive `out_valid` cycles, in order. Hold `out_ready`=0 for 4 cycles mid-stream → `in_ready`=0 throughout, `dout` stable, no loss or duplication.
- Reserved `op`=111, `shamt`=5 → 0xD5; any op with `shamt`=0 → 0xD5.
- Assert `flush` with 3 ops in flight plus a new input → `out_valid` stays 0 for the next 3 cycles; the next accepted op emerges with correct latency.
- `rst` asserted with a full, stalled pipe → next cycle `out_valid`=0, `dout`=0, `in_ready`=1.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA, plus ROL/ROR when PIPELINED_BARREL_SHIFTER_ROTATE_EN is defined.
// Latency: SHW cycles from input to out_valid, plus one per stall cycle; one op per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; flush kills every valid bit.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)  // derived from WIDTH; leave at default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic [2:0]       op;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t stg_q [SHW];
  logic   adv;

  assign out_valid = stg_q[SHW-1].vld;
  assign dout      = stg_q[SHW-1].dat;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // One shift level; sgn is the operand's original MSB, not the current one.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       o,
    input logic             sgn,
    input int               n
  );
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sgn}} & ~({WIDTH{1'b1}} >> n);
    case (o)
      OP_SLL:  shift_level = d << n;
      OP_SRL:  shift_level = d >> n;
      OP_SRA:  shift_level = fill | (d >> n);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
      OP_ROL:  shift_level = (d << n) | (d >> (WIDTH - n));
      OP_ROR:  shift_level = (d >> n) | (d << (WIDTH - n));
`endif
      default: shift_level = d;
    endcase
  endfunction

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    stage_t src;
    stage_t nxt;
    stage_t q;
    logic   unused_fields;

    if (k == 0) begin : g_head
      assign src = '{vld: in_valid, sgn: din[WIDTH-1], op: op, amt: shamt, dat: din};
    end else begin : g_body
      assign src = stg_q[k-1];
    end

    always_comb begin
      nxt = src;
      if (src.amt[k]) begin
        nxt.dat = shift_level(src.dat, src.op, src.sgn, 1 << k);
      end
    end

    // Flush only drops valid bits; stale data may linger behind out_valid = 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (flush) begin
        q.vld <= 1'b0;
      end else if (adv) begin
        q <= nxt;
      end
    end

    assign stg_q[k]      = q;
    // Control fields of a stage are only partly consumed by the stage after it.
    assign unused_fields = ^{q.sgn, q.op, q.amt};
  end

endmodule
